conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Top-level sequencer for the KERN_DIM x KERN_DIM convolver datapath.
- On start, loads KERN_DIM^2 kernel weights into the weight registers, then streams a WIDTH x HEIGHT image raster-order through the line-buffer/window shifter.
- Drives the shift enables and flags each cycle in which the window holds a fully valid KERN_DIM x KERN_DIM neighbourhood, tagging it with its output coordinates.
- Sits between the input stream source and the convolver datapath.

Parameters:
- KERN_DIM, 3, kernel side length.
- WIDTH, 28, image columns.
- HEIGHT, 28, image rows.
- CNT_BW, 5, row/column counter width; must hold max(WIDTH,HEIGHT)-1.
- WADDR_BW, 4, weight index width; must hold KERN_DIM*KERN_DIM-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- weight_valid  in  1  weight word present on the datapath weight bus.
- weight_ready  out  1  sequencer accepts weights (LOAD_W only).
- pixel_valid  in  1  pixel present on the datapath pixel bus.
- pixel_ready  out  1  sequencer accepts pixels (STREAM only).
- load_weight  out  1  write strobe to the weight register at weight_addr.
- weight_addr  out  WADDR_BW  index of weight being written, 0..KERN_DIM^2-1.
- shift_en  out  1  advance line buffers/window by one pixel.
- out_valid  out  1  window output valid this cycle.
- out_row  out  CNT_BW  output row of current valid window.
- out_col  out  CNT_BW  output column of current valid window.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle frame-complete pulse.

Behaviour:
- States: IDLE, LOAD_W, STREAM, DONE; 2-bit encoding.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; all counters=0.
  - out_valid, out_row, out_col, done=0.
  - Combinational outputs then evaluate to 0.
- IDLE:
  - start=1 -> LOAD_W next cycle; w_cnt, row, col cleared.
  - weight_valid/pixel_valid ignored.
- LOAD_W:
  - weight_ready=1.
  - On weight_valid&&weight_ready: load_weight=1 combinationally same cycle, weight_addr=w_cnt, w_cnt increments.
  - Handshake on w_cnt=KERN_DIM^2-1 -> STREAM; w_cnt returns to 0.
  - No handshake: hold, no strobe.
- STREAM:
  - pixel_ready=1.
  - On pixel_valid&&pixel_ready: shift_en=1 combinationally same cycle; col increments.
  - At col=WIDTH-1: col wraps to 0, row increments.
  - Handshake on row=HEIGHT-1, col=WIDTH-1 -> DONE.
  - Stalls (pixel_valid=0): counters hold, shift_en=0, no output.
- Window validity (registered, latency 1):
  - out_valid(t+1)=1 iff a pixel was accepted at t with row>=KERN_DIM-1 and col>=KERN_DIM-1.
  - Then out_row=row-(KERN_DIM-1) and out_col=col-(KERN_DIM-1) of that pixel.
  - Otherwise out_valid=0; out_row/out_col hold their last value.
  - Outputs per frame: (WIDTH-KERN_DIM+1)*(HEIGHT-KERN_DIM+1) = 676 at defaults.
  - out_col ranges 0..25; out_row ranges 0..25.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - The final out_valid (out_row=25, out_col=25) coincides with the done cycle.
- start while busy: ignored, no restart.
- weight_ready and pixel_ready are never high simultaneously; neither is high in IDLE or DONE.
- busy=1 in LOAD_W, STREAM, DONE; busy falls the cycle after done.
- Counters never exceed their limits; no wrap past HEIGHT-1.

Test Plan:
- Reset then start, 9 back-to-back weights:
  - load_weight pulses 9 cycles with weight_addr 0..8.
  - pixel_ready rises the cycle after addr 8 is accepted.
- Full frame, 784 pixels with pixel_valid held high:
  - out_valid rises 1 cycle after pixel (row2,col2) is accepted, with out_row=0, out_col=0.
  - Exactly 676 out_valid pulses.
  - Last pulse has out_row=25, out_col=25 and coincides with done.
  - busy=0 the next cycle.
- Pixel stream with pixel_valid low every third cycle:
  - shift_en only on handshake cycles.
  - Same 676 outputs with identical coordinate sequence.
- Weight stalls (weight_valid 1,0,0,1...):
  - No strobe during gaps.
  - w_cnt holds; exactly 9 strobes.
- start pulsed mid-STREAM at row 10: no effect; counters continue.
- reset asserted mid-STREAM (row 12, col 7):
  - All outputs 0 immediately, IDLE.
  - New start reloads weights from addr 0.

Source files
------------

// File: rtl/conv_sequencer.sv
// Frame sequencer for the KERN_DIM x KERN_DIM convolver: loads the kernel weights,
// then streams one raster-order image and tags every fully valid window with its coordinates.
module conv_sequencer #(
  parameter int KERN_DIM = 3,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int CNT_BW   = 5,
  parameter int WADDR_BW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                weight_valid,
  output logic                weight_ready,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic                load_weight,
  output logic [WADDR_BW-1:0] weight_addr,
  output logic                shift_en,
  output logic                out_valid,
  output logic [CNT_BW-1:0]   out_row,
  output logic [CNT_BW-1:0]   out_col,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [WADDR_BW-1:0] W_LAST   = WADDR_BW'(KERN_DIM * KERN_DIM - 1);
  localparam logic [CNT_BW-1:0]   COL_LAST = CNT_BW'(WIDTH - 1);
  localparam logic [CNT_BW-1:0]   ROW_LAST = CNT_BW'(HEIGHT - 1);
  localparam logic [CNT_BW-1:0]   K_OFF    = CNT_BW'(KERN_DIM - 1);

  state_t              state;
  logic [WADDR_BW-1:0] w_cnt;
  logic [CNT_BW-1:0]   row;
  logic [CNT_BW-1:0]   col;
  logic                w_hs;
  logic                p_hs;

  // Handshakes: a word transfers in the cycle where valid && ready are both high;
  // ready depends only on state, never on valid, and the strobe is asserted that same cycle.
  assign weight_ready = (state == S_LOAD_W);
  assign pixel_ready  = (state == S_STREAM);
  assign w_hs         = weight_valid && weight_ready;
  assign p_hs         = pixel_valid && pixel_ready;
  assign load_weight  = w_hs;
  assign shift_en     = p_hs;
  assign weight_addr  = w_cnt;
  assign busy         = (state != S_IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      w_cnt     <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD_W;
            w_cnt <= '0;
            row   <= '0;
            col   <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_hs) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= S_STREAM;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (p_hs) begin
            // The window is complete once KERN_DIM rows and columns have been shifted in.
            if (row >= K_OFF && col >= K_OFF) begin
              out_valid <= 1'b1;
              out_row   <= row - K_OFF;
              out_col   <= col - K_OFF;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: table-driven weight loading, randomized pixel streams
// scored against a coordinate list built from the image geometry.
module tb_conv_sequencer;

  localparam int K  = 3;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int CB = 5;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          weight_valid;
  logic          weight_ready;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          load_weight;
  logic [AB-1:0] weight_addr;
  logic          shift_en;
  logic          out_valid;
  logic [CB-1:0] out_row;
  logic [CB-1:0] out_col;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  conv_sequencer #(
    .KERN_DIM(K), .WIDTH(W), .HEIGHT(H), .CNT_BW(CB), .WADDR_BW(AB)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .load_weight(load_weight), .weight_addr(weight_addr),
    .shift_en(shift_en), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic          exp_load;
    logic [AB-1:0] exp_addr;
    logic          exp_wr;
    logic          exp_pr;
  } wvec_t;

  wvec_t                 wtbl[$];
  logic [2*CB-1:0]       exp_q[$];
  logic                  exp_ov;
  int                    n_vec = 0;
  int                    n_err = 0;
  int                    n_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One sample point per cycle: window timing, coordinates and ready exclusivity.
  task automatic step();
    logic [2*CB-1:0] e;
    @(negedge clk);
    chk("out_valid", out_valid, exp_ov);
    if (out_valid) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_extra: got row %0d col %0d expected no output", out_row, out_col);
      end else begin
        e = exp_q.pop_front();
        chk("out_coord", {out_row, out_col}, e);
      end
    end
    chk("ready_excl", weight_ready & pixel_ready, 0);
  endtask

  function automatic void build_wtbl(input int mode);
    int acc = 0;
    int cyc = 0;
    logic wv;
    wtbl.delete();
    while (acc < K * K) begin
      if (mode == 0) wv = 1'b1;
      else if (mode == 1) wv = (cyc % 3 == 0);
      else wv = 1'($urandom_range(0, 1));
      wtbl.push_back('{wv, wv, AB'(acc), 1'b1, 1'b0});
      if (wv) acc++;
      cyc++;
    end
    // First STREAM cycle: further weights must be ignored.
    wtbl.push_back('{1'b1, 1'b0, AB'(0), 1'b0, 1'b1});
  endfunction

  task automatic do_start_and_load(input int mode);
    int strobes = 0;
    @(posedge clk); #1;
    start = 1'b1;
    exp_ov = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_wready", weight_ready, 0);
    build_wtbl(mode);
    foreach (wtbl[i]) begin
      @(posedge clk); #1;
      start = 1'b0;
      weight_valid = wtbl[i].wv;
      step();
      chk("load_weight", load_weight, wtbl[i].exp_load);
      chk("weight_addr", weight_addr, wtbl[i].exp_addr);
      chk("weight_ready", weight_ready, wtbl[i].exp_wr);
      chk("pixel_ready", pixel_ready, wtbl[i].exp_pr);
      chk("load_busy", busy, 1);
      if (load_weight) strobes++;
    end
    weight_valid = 1'b0;
    chk("strobe_count", strobes, K * K);
  endtask

  // mode 0: valid held high, 1: low every third cycle, 2: random.
  task automatic run_frame(input int mode, input int start_pix, input int reset_pix);
    int p = 0;
    int cyc = 0;
    logic acc;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r >= K - 1 && c >= K - 1) exp_q.push_back({CB'(r - (K - 1)), CB'(c - (K - 1))});
    n_pulse = 0;
    exp_ov = 1'b0;
    while (p < W * H && cyc < 6000) begin
      @(posedge clk); #1;
      if (p == reset_pix) begin
        pixel_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pready", pixel_ready, 0);
        chk("rst_shift", shift_en, 0);
        chk("rst_wready", weight_ready, 0);
        chk("rst_waddr", weight_addr, 0);
        pixel_valid = 1'b0;
        exp_q.delete();
        exp_ov = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        return;
      end
      if (mode == 0) pixel_valid = 1'b1;
      else if (mode == 1) pixel_valid = (cyc % 3 != 2);
      else pixel_valid = ($urandom_range(0, 3) != 0);
      start = (p == start_pix);
      step();
      chk("stream_pready", pixel_ready, 1);
      chk("stream_busy", busy, 1);
      chk("stream_done", done, 0);
      acc = pixel_valid;
      chk("shift_en", shift_en, acc);
      exp_ov = acc && (p / W >= K - 1) && (p % W >= K - 1);
      if (acc) p++;
      cyc++;
    end
    start = 1'b0;
    if (p < W * H) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got %0d pixels expected %0d", p, W * H);
      return;
    end
    @(posedge clk); #1;
    pixel_valid = 1'b1;
    step();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_pready", pixel_ready, 0);
    chk("done_shift", shift_en, 0);
    chk("last_row", out_row, H - K);
    chk("last_col", out_col, W - K);
    exp_ov = 1'b0;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    step();
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
    chk("pulse_count", n_pulse, (W - K + 1) * (H - K + 1));
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    weight_valid = 1'b0;
    pixel_valid = 1'b0;
    exp_ov = 1'b0;
    n_pulse = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_waddr", weight_addr, 0);
    chk("reset_row", out_row, 0);
    chk("reset_col", out_col, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE ignores valids.
    weight_valid = 1'b1;
    pixel_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      step();
      chk("idle_load", load_weight, 0);
      chk("idle_shift", shift_en, 0);
      chk("idle_busy", busy, 0);
    end
    weight_valid = 1'b0;
    pixel_valid = 1'b0;

    do_start_and_load(0);
    run_frame(0, -1, -1);

    do_start_and_load(1);
    run_frame(1, 10 * W, -1);

    do_start_and_load(2);
    run_frame(2, -1, 12 * W + 7);

    do_start_and_load(0);
    run_frame(2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
